wb_arbiter2: RTL and testbench

Two-master Wishbone classic arbiter with a bus watchdog. It sits between the CPU-side bus interface unit (master 0) and a second bus master such as a DMA or video fetch engine (master 1), and shares the single Wishbone slave port (address window 0x3xxx_xxxx) between them. It grants masters round-robin and holds each grant for a whole cycle. A watchdog terminates stalled transfers with an error.

---
 rtl/wb_arbiter2_pkg.sv | 50 +++++
 rtl/wb_watchdog.sv | 39 +++
 rtl/wb_arbiter2.sv | 180 ++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Holds bus widths, FSM state encodings, the default watchdog limit and the
// packed request/response payloads used by the arbiter mux.
package wb_arbiter2_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  // Default watchdog limit and counter width (2**CNT_W must exceed TIMEOUT).
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Master-to-slave request payload.
  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

  // Slave-to-master response payload.
  typedef struct packed {
    logic [DAT_W-1:0] dat;
    logic             ack;
    logic             err;
    logic             rty;
  } wb_rsp_t;

  // One-hot grant vector for a state (bit0 = master 0, bit1 = master 1).
  function automatic logic [1:0] gnt_of(input state_e st);
    logic [1:0] g;
    g = 2'b00;
    case (st)
      ST_OWN0: g = 2'b01;
      ST_OWN1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog counter.
// Counts consecutive stalled strobe cycles and raises fire in the cycle the
// count equals TIMEOUT; the counter then restarts from zero.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   run       owner is strobing with no ack/err/rty this cycle
//   clr       ownership is ending (owner cyc low) or the bus is idle
//   fire      combinational: stalled for TIMEOUT cycles, terminate now
module wb_watchdog
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic fire
);

  logic [CNT_W-1:0] cnt;

  // Fire only while still stalled; a response in the same cycle wins.
  assign fire = run && (cnt == CNT_W'(TIMEOUT));

  // Stall counter; clears on termination, idle strobe, handoff or firing,
  // so it never reaches the wrap point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !run || fire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter with bus watchdog.
// Master 0 (CPU BIU) and master 1 (DMA/video) share one slave port. Grants are
// round-robin and held for a whole cycle (until the owner drops cyc). The
// owner's request and the slave response pass through combinationally; the
// watchdog terminates a stalled transfer with err.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mX_cyc/stb/we/adr/sel/dat_i   master X request
//   mX_dat/ack/err/rty_o     response to master X (zero unless X owns)
//   s_cyc/stb/we/adr/sel/dat_o    slave request (zero when idle)
//   s_dat/ack/err/rty_i      slave response
//   gnt_o                    one-hot current owner, 00 when idle
//   wdt_evt_o                single-cycle pulse when the watchdog fires
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  // master 0
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_rty_o,
  // master 1
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_rty_o,
  // slave
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  // status
  output logic [1:0]       gnt_o,
  output logic             wdt_evt_o
);

  state_e  state;
  logic    last;      // most recent owner; reset to 1 so master 0 wins the first tie

  wb_req_t m0_req;
  wb_req_t m1_req;
  wb_req_t own_req;
  wb_rsp_t s_rsp;
  wb_rsp_t rsp0;
  wb_rsp_t rsp1;

  logic    resp_any;
  logic    wd_run;
  logic    wd_clr;
  logic    wd_fire;
  logic    own0;
  logic    own1;

  assign m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                    adr: m0_adr_i, sel: m0_sel_i, dat: m0_dat_i};
  assign m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                    adr: m1_adr_i, sel: m1_sel_i, dat: m1_dat_i};
  assign s_rsp  = '{dat: s_dat_i, ack: s_ack_i, err: s_err_i, rty: s_rty_i};

  assign own0 = (state == ST_OWN0);
  assign own1 = (state == ST_OWN1);

  // Arbitration FSM: grant from IDLE round-robin, hand off without a dead
  // cycle when the other master is already waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state <= last ? ST_OWN0 : ST_OWN1;
          end else if (m0_cyc_i) begin
            state <= ST_OWN0;
          end else if (m1_cyc_i) begin
            state <= ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (!m0_cyc_i) begin
            last  <= 1'b0;
            state <= m1_cyc_i ? ST_OWN1 : ST_IDLE;
          end
        end
        ST_OWN1: begin
          if (!m1_cyc_i) begin
            last  <= 1'b1;
            state <= m0_cyc_i ? ST_OWN0 : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Owner mux: request forward, response routed back to the owner only.
  always_comb begin
    own_req = '0;
    rsp0    = '0;
    rsp1    = '0;
    case (state)
      ST_OWN0: begin
        own_req = m0_req;
        rsp0    = s_rsp;
      end
      ST_OWN1: begin
        own_req = m1_req;
        rsp1    = s_rsp;
      end
      default: begin
        own_req = '0;
      end
    endcase
  end

  assign resp_any = s_ack_i | s_err_i | s_rty_i;
  assign wd_run   = own_req.cyc & own_req.stb & ~resp_any;
  // own_req.cyc is low both when idle and in the owner's release cycle.
  assign wd_clr   = ~own_req.cyc;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdt (
    .clk  (clk),
    .rst  (rst),
    .run  (wd_run),
    .clr  (wd_clr),
    .fire (wd_fire)
  );

  // Slave side; a watchdog fire withdraws the cycle in the same clock.
  assign s_cyc_o = own_req.cyc & ~wd_fire;
  assign s_stb_o = own_req.stb & ~wd_fire;
  assign s_we_o  = own_req.we;
  assign s_adr_o = own_req.adr;
  assign s_sel_o = own_req.sel;
  assign s_dat_o = own_req.dat;

  // Master side; watchdog error is merged into the owner's err.
  assign m0_dat_o = rsp0.dat;
  assign m0_ack_o = rsp0.ack;
  assign m0_err_o = rsp0.err | (wd_fire & own0);
  assign m0_rty_o = rsp0.rty;

  assign m1_dat_o = rsp1.dat;
  assign m1_ack_o = rsp1.ack;
  assign m1_err_o = rsp1.err | (wd_fire & own1);
  assign m1_rty_o = rsp1.rty;

  assign gnt_o     = gnt_of(state);
  assign wdt_evt_o = wd_fire;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus a randomized
// run checked against an owner/stall-count reference model.
module tb_wb_arbiter2;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  mcyc;
  logic [1:0]  mstb;
  logic [1:0]  mwe;
  logic [31:0] madr [2];
  logic [3:0]  msel [2];
  logic [31:0] mwd  [2];

  logic [31:0] mrd  [2];
  logic [1:0]  mack;
  logic [1:0]  merr;
  logic [1:0]  mrty;

  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;
  logic [1:0]  gnt_o;
  logic        wdt_evt_o;

  logic [151:0] all_out;

  int total = 0;
  int bad   = 0;
  int fires = 0;

  // reference model: who owns, who owned last, consecutive stalled cycles
  bit mdl_busy;
  bit mdl_own;
  bit mdl_last;
  int mdl_stall;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]),
    .m0_adr_i(madr[0]), .m0_sel_i(msel[0]), .m0_dat_i(mwd[0]),
    .m0_dat_o(mrd[0]), .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rty_o(mrty[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]),
    .m1_adr_i(madr[1]), .m1_sel_i(msel[1]), .m1_dat_i(mwd[1]),
    .m1_dat_o(mrd[1]), .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rty_o(mrty[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt_o), .wdt_evt_o(wdt_evt_o)
  );

  assign all_out = {mrd[0], mrd[1], mack, merr, mrty, s_cyc_o, s_stb_o, s_we_o,
                    s_adr_o, s_sel_o, s_dat_o, gnt_o, wdt_evt_o};

  function automatic bit model_fire();
    return mdl_busy && mcyc[mdl_own] && mstb[mdl_own] && !(s_ack || s_err || s_rty)
           && (mdl_stall == TO);
  endfunction

  // Apply the clock edge to the model using the inputs of the ending cycle.
  task automatic model_step();
    bit fire;
    bit stalled;
    fire = model_fire();
    if (mdl_busy) begin
      stalled   = mcyc[mdl_own] && mstb[mdl_own] && !(s_ack || s_err || s_rty);
      mdl_stall = (stalled && !fire) ? mdl_stall + 1 : 0;
      if (!mcyc[mdl_own]) begin
        mdl_last = mdl_own;
        mdl_busy = mcyc[~mdl_own];
        mdl_own  = ~mdl_own;
      end
    end else begin
      mdl_stall = 0;
      if (mcyc[0] && mcyc[1]) begin
        mdl_busy = 1'b1;
        mdl_own  = ~mdl_last;
      end else if (mcyc[0] || mcyc[1]) begin
        mdl_busy = 1'b1;
        mdl_own  = mcyc[1];
      end
    end
  endtask

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_own   = 1'b0;
    mdl_last  = 1'b1;
    mdl_stall = 0;
  endtask

  task automatic idle_inputs();
    mcyc = 2'b00; mstb = 2'b00; mwe = 2'b00;
    for (int i = 0; i < 2; i++) begin
      madr[i] = 32'h0; msel[i] = 4'h0; mwd[i] = 32'h0;
    end
    s_dat = 32'h0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    total++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle gnt=%b s_cyc=%b want 00/0", gnt_o, s_cyc_o);
    end
    advance();
  endtask

  task automatic test_single_read();
    do_reset();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h3000_0010; msel[0] = 4'hF;
    settle();
    total++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      bad++; $display("FAIL read_latency gnt=%b s_cyc=%b want 00/0", gnt_o, s_cyc_o);
    end
    advance();
    settle();
    total++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h3000_0010) begin
      bad++; $display("FAIL read_grant gnt=%b s_cyc=%b adr=%h want 01/1/30000010",
                      gnt_o, s_cyc_o, s_adr_o);
    end
    advance();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    settle();
    total++;
    if (mrd[0] !== 32'hDEAD_BEEF || mack[0] !== 1'b1) begin
      bad++; $display("FAIL read_data dat=%h ack=%b want deadbeef/1", mrd[0], mack[0]);
    end
    total++;
    if ({mrd[1], mack[1], merr[1], mrty[1]} !== 35'h0) begin
      bad++; $display("FAIL read_m1_quiet got=%h want 0", {mrd[1], mack[1], merr[1], mrty[1]});
    end
    advance();
    idle_inputs();
    settle();
    advance();
    settle();
    total++;
    if (gnt_o !== 2'b00) begin
      bad++; $display("FAIL read_release gnt=%b want 00", gnt_o);
    end
    advance();
  endtask

  task automatic test_tie();
    do_reset();
    mcyc = 2'b11; mstb = 2'b11;
    madr[0] = 32'h3000_0100; madr[1] = 32'h3000_0200;
    settle();
    advance();
    settle();
    total++;
    if (gnt_o !== 2'b01 || s_adr_o !== 32'h3000_0100) begin
      bad++; $display("FAIL tie_first gnt=%b adr=%h want 01/30000100", gnt_o, s_adr_o);
    end
    advance();
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    settle();
    total++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b0) begin
      bad++; $display("FAIL tie_release gnt=%b s_cyc=%b want 01/0", gnt_o, s_cyc_o);
    end
    advance();
    settle();
    total++;
    if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h3000_0200) begin
      bad++; $display("FAIL tie_handoff gnt=%b s_cyc=%b adr=%h want 10/1/30000200",
                      gnt_o, s_cyc_o, s_adr_o);
    end
    advance();
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    settle();
    advance();
    mcyc = 2'b11; mstb = 2'b11;
    settle();
    total++;
    if (gnt_o !== 2'b00) begin
      bad++; $display("FAIL tie_idle gnt=%b want 00", gnt_o);
    end
    advance();
    settle();
    total++;
    if (gnt_o !== 2'b01) begin
      bad++; $display("FAIL tie_second gnt=%b want 01", gnt_o);
    end
    idle_inputs();
    advance();
    settle();
    advance();
  endtask

  task automatic test_no_preempt();
    logic [31:0] d;
    do_reset();
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h3000_0400;
    settle();
    advance();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h3000_0800;
    for (int k = 0; k < 4; k++) begin
      d = $urandom();
      s_ack = 1'b1; s_dat = d;
      settle();
      total++;
      if (gnt_o !== 2'b10 || mack !== 2'b10 || mrd[1] !== d || mrd[0] !== 32'h0) begin
        bad++; $display("FAIL burst_%0d gnt=%b ack=%b dat1=%h dat0=%h want 10/10/%h/0",
                        k, gnt_o, mack, mrd[1], mrd[0], d);
      end
      advance();
    end
    s_ack = 1'b0; s_dat = 32'h0;
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    settle();
    total++;
    if (gnt_o !== 2'b10) begin
      bad++; $display("FAIL burst_hold gnt=%b want 10", gnt_o);
    end
    advance();
    settle();
    total++;
    if (gnt_o !== 2'b01 || s_adr_o !== 32'h3000_0800) begin
      bad++; $display("FAIL burst_switch gnt=%b adr=%h want 01/30000800", gnt_o, s_adr_o);
    end
    idle_inputs();
    advance();
    settle();
    advance();
  endtask

  // ack_at_to=1: slave acks exactly in the timeout cycle and must win.
  task automatic test_watchdog(input bit ack_at_to);
    logic [3:0] got;
    logic [3:0] want;
    do_reset();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h3000_1000;
    settle();
    advance();
    for (int i = 0; i <= TO + 1; i++) begin
      s_ack = ack_at_to && (i == TO);
      settle();
      got = {mack[0], merr[0], wdt_evt_o, s_stb_o};
      if (i != TO)       want = 4'b0001;
      else if (ack_at_to) want = 4'b1001;
      else               want = 4'b0110;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL wdt%0d_cycle%0d ack/err/evt/stb=%b want %b", ack_at_to, i, got, want);
      end
      if (i == TO && !ack_at_to) begin
        total++;
        if (s_cyc_o !== 1'b0) begin
          bad++; $display("FAIL wdt_cyc_drop s_cyc=%b want 0", s_cyc_o);
        end
      end
      advance();
    end
    idle_inputs();
    settle();
    advance();
    settle();
    advance();
  endtask

  task automatic test_async_reset();
    do_reset();
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h3000_2000;
    settle();
    advance();
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    settle();
    total++;
    if (mack[1] !== 1'b1 || gnt_o !== 2'b10) begin
      bad++; $display("FAIL areset_pre ack1=%b gnt=%b want 1/10", mack[1], gnt_o);
    end
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL areset_outputs got=%h want=0", all_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    total++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || mack[1] !== 1'b0) begin
      bad++; $display("FAIL areset_idle gnt=%b s_cyc=%b ack1=%b want 00/0/0", gnt_o, s_cyc_o, mack[1]);
    end
    idle_inputs();
    advance();
  endtask

  task automatic rand_master(input bit m);
    if (!mcyc[m]) mcyc[m] = ($urandom_range(0, 99) < 30);
    else if ($urandom_range(0, 99) < 10) mcyc[m] = 1'b0;
    mstb[m] = mcyc[m] && ($urandom_range(0, 99) < 90);
    mwe[m]  = $urandom_range(0, 1) == 1;
    madr[m] = {4'h3, 28'($urandom())};
    msel[m] = 4'($urandom());
    mwd[m]  = $urandom();
  endtask

  task automatic test_random();
    int          stall_left;
    bit          fire;
    bit          o;
    logic [1:0]  e_gnt;
    logic [70:0] e_s;
    logic [34:0] e_m [2];
    stall_left = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_master(1'b0);
      rand_master(1'b1);
      if (stall_left > 0) begin
        stall_left--;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 4) stall_left = int'($urandom_range(6, 14));
        s_ack = ($urandom_range(0, 99) < 30);
        s_err = ($urandom_range(0, 99) < 5);
        s_rty = ($urandom_range(0, 99) < 5);
      end
      s_dat = $urandom();
      settle();

      fire  = model_fire();
      o     = mdl_own;
      e_gnt = 2'b00;
      e_s   = '0;
      e_m[0] = '0;
      e_m[1] = '0;
      if (mdl_busy) begin
        e_gnt    = o ? 2'b10 : 2'b01;
        e_s      = {mcyc[o] & ~fire, mstb[o] & ~fire, mwe[o], madr[o], msel[o], mwd[o]};
        e_m[o]   = {s_dat, s_ack, s_err | fire, s_rty};
      end
      if (fire) fires++;

      total++;
      if (gnt_o !== e_gnt) begin
        bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, gnt_o, e_gnt);
      end
      total++;
      if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !== e_s) begin
        bad++; $display("FAIL rnd_slave c=%0d got=%h want=%h", c,
                        {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}, e_s);
      end
      total++;
      if ({mrd[0], mack[0], merr[0], mrty[0]} !== e_m[0]) begin
        bad++; $display("FAIL rnd_m0 c=%0d got=%h want=%h", c,
                        {mrd[0], mack[0], merr[0], mrty[0]}, e_m[0]);
      end
      total++;
      if ({mrd[1], mack[1], merr[1], mrty[1]} !== e_m[1]) begin
        bad++; $display("FAIL rnd_m1 c=%0d got=%h want=%h", c,
                        {mrd[1], mack[1], merr[1], mrty[1]}, e_m[1]);
      end
      total++;
      if (wdt_evt_o !== fire) begin
        bad++; $display("FAIL rnd_wdt c=%0d got=%b want=%b", c, wdt_evt_o, fire);
      end
      advance();
    end
    $display("random run: watchdog events seen=%0d", fires);
    idle_inputs();
    settle();
    advance();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_no_preempt();
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
